pcs_rx_link_ctrl: RTL and testbench
===================================

PCS_RX_LINK_CTRL -- requirements
Module: pcs_rx_link_ctrl

Interface
REQ-001 SHALL have parameter IS_10G, default 0; 1 = single lane, no alignment markers.
REQ-002 SHALL have parameter LANE_N, default 4; number of lanes.
REQ-003 SHALL have parameter HEAD_W, default 2; sync header width.
REQ-004 SHALL have parameter STABLE_N, default 8; cycles all locks must hold before link up (>=1).
REQ-005 SHALL have parameters BER_WIN_N, default 3125 (window cycles), and BER_THRESH, default 97 (bad headers per window); CNT_W = $clog2(BER_THRESH+1).
REQ-006 SHALL have port clk, input, 1; sole clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1; asynchronous, active-high reset.
REQ-008 SHALL have port valid_i, input, LANE_N; per-lane serdes block valid.
REQ-009 SHALL have port head_i, input, LANE_N*HEAD_W; per-lane sync header, lane l at [l*HEAD_W +: HEAD_W].
REQ-010 SHALL have port bs_lock_v_i, input, LANE_N; per-lane block sync lock.
REQ-011 SHALL have port am_lock_v_i, input, LANE_N; per-lane alignment marker lock (ignored when IS_10G=1).
REQ-012 SHALL have port deskew_v_i, input, 1; deskew reports lanes aligned (ignored when IS_10G=1).
REQ-013 SHALL have port dp_flush_o, output, 1; holds deskew/descrambler state cleared.
REQ-014 SHALL have port link_up_o, output, 1; gates the datapath valid to the MAC.
REQ-015 SHALL have port hi_ber_o, output, 1; high bit error rate flag.
REQ-016 SHALL have port state_o, output, 3; current FSM state encoding.
REQ-017 SHALL have port ber_cnt_o, output, CNT_W; bad header count in current window.

Function
REQ-018 SHALL implement states RESET=0, WAIT_BS=1, WAIT_AM=2, WAIT_DESKEW=3, STABLE=4, UP=5, HI_BER=6; state 7 unreachable, decodes to RESET.
REQ-019 RESET SHALL go to WAIT_BS on the first clock after reset deassertion.
REQ-020 WAIT_BS SHALL go to WAIT_AM when &bs_lock_v_i (IS_10G=1: to STABLE).
REQ-021 WAIT_AM SHALL go to WAIT_DESKEW when &am_lock_v_i.
REQ-022 WAIT_DESKEW SHALL go to STABLE when deskew_v_i=1.
REQ-023 STABLE SHALL count cycles from 0 and go to UP in the cycle the count reaches STABLE_N-1; counter cleared on STABLE entry.
REQ-024 "Locks ok" = &bs_lock_v_i, plus &am_lock_v_i and deskew_v_i when IS_10G=0.
REQ-025 In WAIT_AM through HI_BER, loss of any lock required by that state SHALL go to WAIT_BS next cycle, taking priority over every other transition.
REQ-026 dp_flush_o SHALL be 1 in RESET, WAIT_BS, WAIT_AM; 0 otherwise.
REQ-027 link_up_o SHALL be 1 only in UP; state_o SHALL equal the state register; all outputs registered or decoded from registers only.
REQ-028 A bad header is valid_i[l]=1 with head_i lane value 2'b00 or 2'b11; per-cycle bad count sums all lanes.
REQ-029 ber_cnt_o SHALL accumulate bad count in UP and HI_BER, saturate at BER_THRESH, clear in all other states.
REQ-030 The window counter SHALL run 0..BER_WIN_N-1 in UP/HI_BER; at wrap ber_cnt_o clears and restarts with that cycle's bad count.
REQ-031 UP SHALL go to HI_BER in the cycle after accumulated count reaches BER_THRESH, including reach on a window-final cycle.
REQ-032 HI_BER SHALL go to UP at a window wrap where the window's count stayed < BER_THRESH.
REQ-033 hi_ber_o SHALL be 1 only in HI_BER.

Reset
REQ-034 While reset=1: state RESET, dp_flush_o=1, link_up_o=0, hi_ber_o=0, ber_cnt_o=0, all counters 0.
REQ-035 Reset asserted mid-operation SHALL force the above asynchronously, independent of clk.

Configuration
REQ-036 With PCS_RX_LINK_CTRL_BER_MON_EN defined, REQ-028..REQ-033 are implemented.
REQ-037 Without it: no BER counters, hi_ber_o=0, ber_cnt_o=0, HI_BER unreachable, UP left only on lock loss.

Verification
REQ-038 IS_10G=0, STABLE_N=8: all bs locks, then am locks, then deskew_v_i, each 1 cycle apart -> states 1,2,3,4; link_up_o=1 exactly 8 cycles after STABLE entry.
REQ-039 In UP, drop bs_lock_v_i[2] for 1 cycle -> next cycle state WAIT_BS, dp_flush_o=1, link_up_o=0, ber_cnt_o=0.
REQ-040 Macro on, BER_WIN_N=16, BER_THRESH=4: 4 lanes head 2'b11 one cycle in UP -> ber_cnt_o=4, hi_ber_o=1 next cycle; clean window -> UP at wrap.
REQ-041 Macro on: 3 bad headers per window (THRESH=4) over 3 windows -> hi_ber_o stays 0, ber_cnt_o clears at each wrap.
REQ-042 IS_10G=1: bs_lock only -> WAIT_BS to STABLE directly, am_lock_v_i/deskew_v_i toggling has no effect.
REQ-043 Assert reset mid-STABLE between clock edges -> outputs reach reset values before next edge; macro off -> hi_ber_o never 1 under REQ-040 stimulus.

Source files
------------

// File: rtl/pcs_rx_link_ctrl.sv
// pcs_rx_link_ctrl
// Receive-side PCS link controller. Brings the link up in the order
// block lock -> alignment-marker lock -> deskew -> stability hold, raises
// link_up_o only in UP, and falls back to WAIT_BS as soon as any lock the
// current state depends on is lost.
//
// Optional feature: define PCS_RX_LINK_CTRL_BER_MON_EN to build the
// sync-header bit-error-rate monitor (bad-header window counter and the
// HI_BER state). Without the macro, hi_ber_o and ber_cnt_o are constant 0
// and UP is left only on lock loss.
module pcs_rx_link_ctrl #(
  parameter int IS_10G     = 0,
  parameter int LANE_N     = 4,
  parameter int HEAD_W     = 2,
  parameter int STABLE_N   = 8,
  parameter int BER_WIN_N  = 3125,
  parameter int BER_THRESH = 97,
  parameter int CNT_W      = $clog2(BER_THRESH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N-1:0]        valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N-1:0]        bs_lock_v_i,
  input  logic [LANE_N-1:0]        am_lock_v_i,
  input  logic                     deskew_v_i,
  output logic                     dp_flush_o,
  output logic                     link_up_o,
  output logic                     hi_ber_o,
  output logic [2:0]               state_o,
  output logic [CNT_W-1:0]         ber_cnt_o
);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_BS     = 3'd1,
    ST_WAIT_AM     = 3'd2,
    ST_WAIT_DESKEW = 3'd3,
    ST_STABLE      = 3'd4,
    ST_UP          = 3'd5,
    ST_HI_BER      = 3'd6
  } state_t;

  // Stability hold counter runs 0..STABLE_N-1 inside STABLE.
  localparam int              STB_W    = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_N - 1);

  state_t           state_q, state_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic             dp_flush_q, dp_flush_d;
  logic             link_up_q, link_up_d;
  logic             hi_ber_q, hi_ber_d;

  // Lock qualification. A 10G link has one lane and no alignment markers,
  // so AM lock and deskew are treated as permanently satisfied.
  logic bs_ok;
  logic am_ok;
  logic dsk_ok;
  logic locks_ok;

  assign bs_ok    = &bs_lock_v_i;
  assign am_ok    = (IS_10G != 0) ? 1'b1 : (&am_lock_v_i);
  assign dsk_ok   = (IS_10G != 0) ? 1'b1 : deskew_v_i;
  assign locks_ok = bs_ok & am_ok & dsk_ok;

  // AM lock and deskew are configuration-dependent; keep them referenced
  // for the 10G build where they carry no meaning.
  logic unused_cfg_inputs;
  assign unused_cfg_inputs = ^{am_lock_v_i, deskew_v_i};

  // Events from the BER monitor consumed by the FSM.
  logic ber_hit;   // accumulated window count reaches threshold this cycle
  logic win_last;  // this cycle is the final cycle of a BER window

`ifdef PCS_RX_LINK_CTRL_BER_MON_EN
  localparam int               WIN_W    = (BER_WIN_N > 1) ? $clog2(BER_WIN_N) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WIN_N - 1);
  localparam int               BAD_W    = $clog2(LANE_N + 1);
  localparam int               SUM_W    = CNT_W + BAD_W + 1;

  logic [LANE_N-1:0] bad_lane;
  logic [BAD_W-1:0]  bad_sum;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  ber_cnt_q, ber_cnt_d;
  logic [SUM_W-1:0]  acc;
  logic              mon_active;
  logic              mon_keep;
  logic              win_first;

  // A valid block whose sync header is all-zeros or all-ones is a bad header.
  genvar gi;
  generate
    for (gi = 0; gi < LANE_N; gi++) begin : g_bad
      logic [HEAD_W-1:0] hd;
      assign hd           = head_i[gi*HEAD_W +: HEAD_W];
      assign bad_lane[gi] = valid_i[gi] & ((hd == '0) | (hd == '1));
    end
  endgenerate

  // Count bad headers across all lanes for this cycle.
  always_comb begin
    bad_sum = '0;
    for (int l = 0; l < LANE_N; l++) begin
      bad_sum = bad_sum + BAD_W'(bad_lane[l]);
    end
  end

  // Window total including this cycle; the first cycle of a window restarts
  // from this cycle's bad count alone, so the finished window's total is
  // visible on ber_cnt_o during that first cycle.
  always_comb begin
    mon_active = (state_q == ST_UP) || (state_q == ST_HI_BER);
    win_first  = (win_cnt_q == '0);
    win_last   = mon_active && (win_cnt_q == WIN_LAST);
    acc        = win_first ? SUM_W'(bad_sum)
                           : (SUM_W'(ber_cnt_q) + SUM_W'(bad_sum));
    ber_hit    = mon_active && (acc >= SUM_W'(BER_THRESH));
  end

  // Next window position and saturating count; both clear whenever the FSM
  // is, or is about to be, outside UP/HI_BER.
  always_comb begin
    mon_keep  = (state_d == ST_UP) || (state_d == ST_HI_BER);
    win_cnt_d = '0;
    ber_cnt_d = '0;
    if (mon_active && mon_keep) begin
      win_cnt_d = win_last ? '0 : (win_cnt_q + WIN_W'(1));
      ber_cnt_d = ber_hit ? CNT_W'(BER_THRESH) : acc[CNT_W-1:0];
    end
  end

  // BER window and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= '0;
      ber_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      ber_cnt_q <= ber_cnt_d;
    end
  end

  assign ber_cnt_o = ber_cnt_q;
`else
  // Monitor absent: header inputs have no consumer and HI_BER cannot be hit.
  logic unused_ber_inputs;
  assign unused_ber_inputs = ^{valid_i, head_i};
  assign ber_hit           = 1'b0;
  assign win_last          = 1'b0;
  assign ber_cnt_o         = '0;
`endif

  // Next-state logic; lock loss outranks every other transition.
  always_comb begin
    state_d   = state_q;
    stb_cnt_d = '0;
    case (state_q)
      ST_WAIT_BS: begin
        if (bs_ok) begin
          state_d = (IS_10G != 0) ? ST_STABLE : ST_WAIT_AM;
        end
      end
      ST_WAIT_AM: begin
        if (!bs_ok) begin
          state_d = ST_WAIT_BS;
        end else if (am_ok) begin
          state_d = ST_WAIT_DESKEW;
        end
      end
      ST_WAIT_DESKEW: begin
        if (!(bs_ok && am_ok)) begin
          state_d = ST_WAIT_BS;
        end else if (dsk_ok) begin
          state_d = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!locks_ok) begin
          state_d = ST_WAIT_BS;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d = ST_UP;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      ST_UP: begin
        if (!locks_ok) begin
          state_d = ST_WAIT_BS;
        end else if (ber_hit) begin
          state_d = ST_HI_BER;
        end
      end
      ST_HI_BER: begin
        if (!locks_ok) begin
          state_d = ST_WAIT_BS;
        end else if (win_last && !ber_hit) begin
          state_d = ST_UP;
        end
      end
      // RESET and the unused code 7 both leave for WAIT_BS on the next edge.
      default: begin
        state_d = ST_WAIT_BS;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    dp_flush_d = (state_d == ST_RESET) || (state_d == ST_WAIT_BS) ||
                 (state_d == ST_WAIT_AM);
    link_up_d  = (state_d == ST_UP);
    hi_ber_d   = (state_d == ST_HI_BER);
  end

  // FSM state, stability counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      stb_cnt_q  <= '0;
      dp_flush_q <= 1'b1;
      link_up_q  <= 1'b0;
      hi_ber_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_cnt_q  <= stb_cnt_d;
      dp_flush_q <= dp_flush_d;
      link_up_q  <= link_up_d;
      hi_ber_q   <= hi_ber_d;
    end
  end

  assign state_o    = state_q;
  assign dp_flush_o = dp_flush_q;
  assign link_up_o  = link_up_q;
  assign hi_ber_o   = hi_ber_q;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// tb_pcs_rx_link_ctrl
// Drives a 4-lane 40G-style instance and a 1-lane 10G instance side by side
// and compares every output after every clock with a cycle-level reference
// model that follows the link bring-up and BER rules directly. Expectations
// for the BER monitor follow PCS_RX_LINK_CTRL_BER_MON_EN.
module tb_pcs_rx_link_ctrl;

  localparam int WIN   = 16;
  localparam int THR   = 4;
  localparam int STB   = 8;
  localparam int STB10 = 3;
  localparam int CW    = $clog2(THR + 1);

`ifdef PCS_RX_LINK_CTRL_BER_MON_EN
  localparam int BER_ON = 1;
`else
  localparam int BER_ON = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 40G-style instance stimulus / observation
  logic [3:0]    valid, bs, am;
  logic [7:0]    head;
  logic          dsk;
  logic          flush0, up0, hib0;
  logic [2:0]    st0;
  logic [CW-1:0] ber0;

  // 10G instance stimulus / observation
  logic          v10, bs10, am10, dsk10;
  logic [1:0]    h10;
  logic          flush1, up1, hib1;
  logic [2:0]    st1;
  logic [CW-1:0] ber1;

  pcs_rx_link_ctrl #(
    .IS_10G(0), .LANE_N(4), .HEAD_W(2), .STABLE_N(STB),
    .BER_WIN_N(WIN), .BER_THRESH(THR)
  ) dut (
    .clk(clk), .reset(reset),
    .valid_i(valid), .head_i(head), .bs_lock_v_i(bs), .am_lock_v_i(am),
    .deskew_v_i(dsk),
    .dp_flush_o(flush0), .link_up_o(up0), .hi_ber_o(hib0),
    .state_o(st0), .ber_cnt_o(ber0)
  );

  pcs_rx_link_ctrl #(
    .IS_10G(1), .LANE_N(1), .HEAD_W(2), .STABLE_N(STB10),
    .BER_WIN_N(WIN), .BER_THRESH(THR)
  ) dut10 (
    .clk(clk), .reset(reset),
    .valid_i(v10), .head_i(h10), .bs_lock_v_i(bs10), .am_lock_v_i(am10),
    .deskew_v_i(dsk10),
    .dp_flush_o(flush1), .link_up_o(up1), .hi_ber_o(hib1),
    .state_o(st1), .ber_cnt_o(ber1)
  );

  int n_checks;
  int n_fail;
  int cyc;
  int bad_total;

  // Reference model: per instance, link state number, cycles spent in the
  // stability hold, and the per-cycle bad counts of the current BER window.
  int m_state [2];
  int m_stb   [2];
  int m_len   [2];
  int m_hist  [2][WIN];
  int e_ber   [2];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0;
      m_stb[k]   = 0;
      m_len[k]   = 0;
      e_ber[k]   = 0;
    end
  endtask

  // Advance the model of instance k by one clock given this cycle's inputs.
  task automatic model_step(input int k, input int lanes, input int is10,
                            input int stable_n, input logic [3:0] vld,
                            input logic [7:0] hd, input logic [3:0] bs_v,
                            input logic [3:0] am_v, input logic dsk_v);
    bit bs_all = 1'b1;
    bit am_all = 1'b1;
    bit dsk_all;
    bit ok;
    int bad   = 0;
    int total = 0;
    int s;
    int nxt;
    logic [1:0] h;
    for (int l = 0; l < lanes; l++) begin
      if (!bs_v[l]) bs_all = 1'b0;
      if (!am_v[l]) am_all = 1'b0;
      h = hd[2*l +: 2];
      if (vld[l] && (h == 2'b00 || h == 2'b11)) bad++;
    end
    dsk_all = dsk_v;
    if (is10 != 0) begin
      am_all  = 1'b1;
      dsk_all = 1'b1;
    end
    ok  = bs_all && am_all && dsk_all;
    s   = m_state[k];
    nxt = s;
    bad_total += bad;
    case (s)
      1: if (bs_all) nxt = (is10 != 0) ? 4 : 2;
      2: if (!bs_all) nxt = 1; else if (am_all) nxt = 3;
      3: if (!(bs_all && am_all)) nxt = 1; else if (dsk_all) nxt = 4;
      4: begin
        if (!ok) nxt = 1;
        else begin
          m_stb[k]++;
          if (m_stb[k] == stable_n) nxt = 5;
        end
      end
      5, 6: begin
        if (!ok) nxt = 1;
        else if (BER_ON != 0) begin
          if (m_len[k] == WIN) m_len[k] = 0;
          m_hist[k][m_len[k]] = bad;
          m_len[k]++;
          for (int i = 0; i < m_len[k]; i++) total += m_hist[k][i];
          if (s == 5 && total >= THR) nxt = 6;
          else if (s == 6 && m_len[k] == WIN && total < THR) nxt = 5;
        end
      end
      default: nxt = 1;
    endcase
    if (nxt == 4 && s != 4) m_stb[k] = 0;
    if (nxt != 5 && nxt != 6) begin
      m_len[k] = 0;
      total    = 0;
    end
    e_ber[k]   = (total > THR) ? THR : total;
    m_state[k] = nxt;
  endtask

  task automatic compare_all();
    check_eq("main.state",    32'(st0),    32'(m_state[0]));
    check_eq("main.dp_flush", 32'(flush0), 32'(m_state[0] <= 2));
    check_eq("main.link_up",  32'(up0),    32'(m_state[0] == 5));
    check_eq("main.hi_ber",   32'(hib0),   32'(m_state[0] == 6));
    check_eq("main.ber_cnt",  32'(ber0),   32'(e_ber[0]));
    check_eq("10g.state",     32'(st1),    32'(m_state[1]));
    check_eq("10g.dp_flush",  32'(flush1), 32'(m_state[1] <= 2));
    check_eq("10g.link_up",   32'(up1),    32'(m_state[1] == 5));
    check_eq("10g.hi_ber",    32'(hib1),   32'(m_state[1] == 6));
    check_eq("10g.ber_cnt",   32'(ber1),   32'(e_ber[1]));
  endtask

  // One clock: model consumes the inputs now on the pins, then outputs are
  // sampled 1 ns after the rising edge.
  task automatic step();
    model_step(0, 4, 0, STB, valid, head, bs, am, dsk);
    model_step(1, 1, 1, STB10, {3'b000, v10}, {6'b000000, h10},
               {3'b000, bs10}, {3'b000, am10}, dsk10);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int up_at;
    int hib_seen;
    int bad_pct;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    bad_total = 0;
    reset = 1'b0;
    valid = 4'h0; head = 8'h66; bs = 4'h0; am = 4'h0; dsk = 1'b0;
    v10 = 1'b0; h10 = 2'b01; bs10 = 1'b0; am10 = 1'b0; dsk10 = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge, then held across two edges.
    #2 reset = 1'b1;
    #1;
    compare_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    reset = 1'b0;
    $display("[tb] reset released at %0t", $time);

    // Ordered bring-up, one lock class per cycle.
    valid = 4'hF; v10 = 1'b1;
    step();
    bs = 4'hF; bs10 = 1'b1;
    step();
    check_eq("10g.direct_to_stable", 32'(st1), 32'd4);
    am = 4'hF;
    step();
    dsk = 1'b1;
    step();
    up_at = 0;
    for (int i = 1; i <= 12; i++) begin
      am10  = 1'($urandom_range(0, 1));
      dsk10 = 1'($urandom_range(0, 1));
      step();
      if (up0 && up_at == 0) up_at = i;
    end
    check_eq("bringup.up_latency", 32'(up_at), 32'd8);
    check_eq("10g.up", 32'(st1), 32'd5);
    $display("[tb] bring-up: link_up after %0d STABLE cycles", up_at);

    // One cycle with every lane carrying a bad header.
    head = 8'hFF;
    step();
    check_eq("ber.burst_count", 32'(ber0), 32'(BER_ON != 0 ? 4 : 0));
    check_eq("ber.burst_hi_ber", 32'(hib0), 32'(BER_ON != 0 ? 1 : 0));
    head = 8'h66;
    repeat (40) step();
    check_eq("ber.recover_up", 32'(st0), 32'd5);
    $display("[tb] bad-header burst and clean recovery done, state %0d", st0);

    // Single-cycle loss of one block lock while up.
    bs = 4'b1011;
    step();
    check_eq("lockloss.state", 32'(st0), 32'd1);
    check_eq("lockloss.flush", 32'(flush0), 32'd1);
    check_eq("lockloss.link_up", 32'(up0), 32'd0);
    check_eq("lockloss.ber_cnt", 32'(ber0), 32'd0);
    bs = 4'hF;
    repeat (15) step();
    check_eq("lockloss.reup", 32'(st0), 32'd5);
    $display("[tb] lane 2 lock glitch and re-lock done, state %0d", st0);

    // Three bad headers per window over three windows: below threshold.
    hib_seen = 0;
    for (int c = 0; c < 3 * WIN; c++) begin
      head = ((c % WIN) == 3) ? 8'b01_11_00_11 : 8'h66;
      step();
      if (hib0) hib_seen = 1;
    end
    head = 8'h66;
    check_eq("ber.sub_thresh_hi_ber", 32'(hib_seen), 32'd0);
    $display("[tb] sub-threshold windows done, hi_ber seen %0d", hib_seen);

    // Reset asserted between edges while in STABLE.
    bs = 4'h0;
    step();
    bs = 4'hF;
    repeat (3) step();
    repeat (2) step();
    check_eq("midreset.pre_state", 32'(st0), 32'd4);
    #3 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    step();
    $display("[tb] asynchronous reset in STABLE done, state %0d", st0);

    // Randomized operation with occasional lock drops and varying error rate.
    bad_pct = 0;
    for (int c = 0; c < 1500; c++) begin
      if ((c % 250) == 0) begin
        case ($urandom_range(0, 3))
          0:       bad_pct = 0;
          1:       bad_pct = 2;
          2:       bad_pct = 8;
          default: bad_pct = 30;
        endcase
        $display("[tb] random segment %0d: bad-header rate %0d%%", c / 250, bad_pct);
      end
      for (int l = 0; l < 4; l++) begin
        bs[l]    = ($urandom_range(0, 999) != 0);
        am[l]    = ($urandom_range(0, 999) != 0);
        valid[l] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 99) < bad_pct)
          head[2*l +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        else
          head[2*l +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      end
      dsk   = ($urandom_range(0, 999) != 0);
      bs10  = ($urandom_range(0, 499) != 0);
      am10  = 1'($urandom_range(0, 1));
      dsk10 = 1'($urandom_range(0, 1));
      v10   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) < bad_pct)
        h10 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      else
        h10 = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      step();
    end
    $display("[tb] random phase done, %0d bad headers presented in total", bad_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
